cp0_exc_ctrl: RTL and testbench
===============================

Name: cp0_exc_ctrl

Overview:
- Sequences the CP0 register file during exception entry and ERET, and owns its single read port and single write port.
- In IDLE, pipeline MFC0/MTC0 accesses pass straight through to CP0.
- On an exception or ERET, the block stalls the pipeline and runs a multi-cycle read-modify-write of Status/Cause/EPC.
- It then issues a one-cycle flush with the redirect PC. It sits between the MEM/commit stage and CP0.

Parameters:
- ADDR_W, 5, CP0 register address width.
- ADDR_STATUS, 12, Status register address.
- ADDR_CAUSE, 13, Cause register address.
- ADDR_EPC, 14, EPC register address.
- EXC_VECTOR, 32'hBFC00380, exception handler entry PC.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- exc_valid  in  1  commit-stage exception request
- exc_code  in  5  ExcCode for Cause[6:2]
- exc_pc  in  32  PC of faulting instruction (already adjusted for delay slot)
- exc_bd  in  1  faulting instruction is in a branch delay slot
- eret_valid  in  1  commit-stage ERET
- mtc0_en  in  1  pipeline CP0 write
- mtc0_addr  in  ADDR_W  pipeline CP0 write address
- mtc0_data  in  32  pipeline CP0 write data
- mfc0_addr  in  ADDR_W  pipeline CP0 read address
- mfc0_data  out  32  pipeline CP0 read data
- cp0_read_addr  out  ADDR_W  to CP0 read port
- cp0_rdata  in  32  from CP0 read port (combinational)
- cp0_write_en  out  1  to CP0 write port
- cp0_write_addr  out  ADDR_W  to CP0 write port
- cp0_write_data  out  32  to CP0 write port
- stall  out  1  freeze pipeline
- flush  out  1  one-cycle pipeline flush
- redirect_pc  out  32  fetch target, valid while flush=1

Behaviour:
- States: IDLE, X_RD_STATUS, X_RD_CAUSE, X_WR_EPC, X_WR_CAUSE, X_WR_STATUS, R_RD_EPC, R_RD_STATUS, R_WR_STATUS, REDIRECT.
- Reset (rst=0 at posedge):
  - state=IDLE; all capture registers cleared.
  - Outputs: cp0_write_en=0, stall=0, flush=0, redirect_pc=0, cp0_read_addr=0, cp0_write_addr=0, cp0_write_data=0; mfc0_data=0 while rst=0.
  - Reset mid-sequence aborts with no further CP0 writes.
- IDLE:
  - cp0_read_addr=mfc0_addr; mfc0_data=cp0_rdata.
  - cp0_write_en/addr/data = mtc0_en/addr/data, unless exc_valid or eret_valid is high this cycle, in which case cp0_write_en=0 (instruction is squashed).
  - stall=0.
- Acceptance, at posedge in IDLE:
  - exc_valid=1: capture exc_code, exc_pc, exc_bd; go to X_RD_STATUS.
  - Else eret_valid=1: go to R_RD_EPC.
  - exc_valid has priority over eret_valid.
- Outside IDLE:
  - stall=1; mfc0_data=0; pipeline write inputs are ignored.
  - exc_valid/eret_valid are ignored (pipeline is frozen).
- Exception path, one cycle per state:
  - X_RD_STATUS: read Status, capture status_q.
  - X_RD_CAUSE: read Cause, capture cause_q. Next state is X_WR_CAUSE if status_q[1] (EXL) = 1, else X_WR_EPC.
  - X_WR_EPC: write EPC = captured exc_pc.
  - X_WR_CAUSE: write Cause = {exc_bd, cause_q[30:7], exc_code, cause_q[1:0]}. CP0 must honour bits 31 and 6:2 on this write.
  - X_WR_STATUS: write Status = status_q | 32'h2 (set EXL).
  - REDIRECT: flush=1, redirect_pc=EXC_VECTOR, stall=1; next state IDLE.
- ERET path:
  - R_RD_EPC: capture epc_q.
  - R_RD_STATUS: capture status_q.
  - R_WR_STATUS: write status_q & ~32'h2.
  - REDIRECT: flush=1, redirect_pc=epc_q.
- Latency, counting the first cycle after acceptance as cycle 1:
  - Exception with EXL=0: flush in cycle 6.
  - Exception with EXL=1: flush in cycle 5.
  - ERET: flush in cycle 4.
- Writes occur only in the WR states, exactly one cycle each. In RD states cp0_write_en=0.
- flush is high for exactly one cycle per accepted request; redirect_pc=0 when flush=0.

Test Plan:
- Pass-through: IDLE, mtc0_en=1, addr 12, data 32'h0000FF01 -> cp0_write_en=1 same cycle, same addr/data. mfc0_addr=13 -> cp0_read_addr=13, mfc0_data=cp0_rdata, stall=0.
- Exception, EXL=0: Status=32'h0000FF01, Cause=32'h00008000, exc_code=5'd4, exc_pc=32'hBFC00100, exc_bd=1.
  - Writes in order: EPC<=32'hBFC00100, Cause<=32'h80008010, Status<=32'h0000FF03.
  - Flush in cycle 6 with redirect_pc=32'hBFC00380; stall=1 in cycles 1-6.
- Exception, EXL=1: Status=32'h00000003 -> no EPC write; Cause then Status<=32'h00000003; flush in cycle 5.
- ERET: EPC=32'h80001234, Status=32'h0000FF03 -> Status<=32'h0000FF01; flush in cycle 4 with redirect_pc=32'h80001234.
- Simultaneous exc_valid+eret_valid+mtc0_en -> mtc0 dropped (no write that cycle), exception path taken, eret ignored.
- Reset mid-op: rst=0 during X_WR_CAUSE -> next cycle IDLE, no Status write, stall=0, flush never asserted.

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/ERET sequencer. Owns the CP0 read and write ports: pipeline MFC0/MTC0
// pass straight through when idle, otherwise Status/Cause/EPC are read-modify-written.
module cp0_exc_ctrl #(
    parameter int unsigned       ADDR_W      = 5,
    parameter logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(12),
    parameter logic [ADDR_W-1:0] ADDR_CAUSE  = ADDR_W'(13),
    parameter logic [ADDR_W-1:0] ADDR_EPC    = ADDR_W'(14),
    parameter logic [31:0]       EXC_VECTOR  = 32'hBFC0_0380
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exc_valid,
    input  logic [4:0]        exc_code,
    input  logic [31:0]       exc_pc,
    input  logic              exc_bd,
    input  logic              eret_valid,
    input  logic              mtc0_en,
    input  logic [ADDR_W-1:0] mtc0_addr,
    input  logic [31:0]       mtc0_data,
    input  logic [ADDR_W-1:0] mfc0_addr,
    output logic [31:0]       mfc0_data,
    output logic [ADDR_W-1:0] cp0_read_addr,
    input  logic [31:0]       cp0_rdata,
    output logic              cp0_write_en,
    output logic [ADDR_W-1:0] cp0_write_addr,
    output logic [31:0]       cp0_write_data,
    output logic              stall,
    output logic              flush,
    output logic [31:0]       redirect_pc
);

    localparam int unsigned DATA_W = 32;
    localparam logic [DATA_W-1:0] EXL_MASK = DATA_W'(2);

    typedef enum logic [3:0] {
        IDLE,
        X_RD_STATUS,
        X_RD_CAUSE,
        X_WR_EPC,
        X_WR_CAUSE,
        X_WR_STATUS,
        R_RD_EPC,
        R_RD_STATUS,
        R_WR_STATUS,
        REDIRECT
    } state_e;

    state_e              state_q;
    logic [4:0]          code_q;
    logic [DATA_W-1:0]   pc_q;
    logic                bd_q;
    logic                eret_q;
    logic [DATA_W-1:0]   status_q;
    logic [DATA_W-1:0]   epc_q;
    logic [23:0]         cause_hi_q;
    logic [1:0]          cause_lo_q;

    // Sequencer state and captured request / CP0 contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            code_q     <= '0;
            pc_q       <= '0;
            bd_q       <= 1'b0;
            eret_q     <= 1'b0;
            status_q   <= '0;
            epc_q      <= '0;
            cause_hi_q <= '0;
            cause_lo_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (exc_valid) begin
                        code_q  <= exc_code;
                        pc_q    <= exc_pc;
                        bd_q    <= exc_bd;
                        eret_q  <= 1'b0;
                        state_q <= X_RD_STATUS;
                    end else if (eret_valid) begin
                        eret_q  <= 1'b1;
                        state_q <= R_RD_EPC;
                    end
                end
                X_RD_STATUS: begin
                    status_q <= cp0_rdata;
                    state_q  <= X_RD_CAUSE;
                end
                X_RD_CAUSE: begin
                    cause_hi_q <= cp0_rdata[30:7];
                    cause_lo_q <= cp0_rdata[1:0];
                    // Nested exception (EXL already set) keeps the original EPC.
                    state_q    <= status_q[1] ? X_WR_CAUSE : X_WR_EPC;
                end
                X_WR_EPC:    state_q <= X_WR_CAUSE;
                X_WR_CAUSE:  state_q <= X_WR_STATUS;
                X_WR_STATUS: state_q <= REDIRECT;
                R_RD_EPC: begin
                    epc_q   <= cp0_rdata;
                    state_q <= R_RD_STATUS;
                end
                R_RD_STATUS: begin
                    status_q <= cp0_rdata;
                    state_q  <= R_WR_STATUS;
                end
                R_WR_STATUS: state_q <= REDIRECT;
                REDIRECT:    state_q <= IDLE;
                default:     state_q <= IDLE;
            endcase
        end
    end

    // Port drive: pass-through in IDLE, sequencer-owned elsewhere, all quiet in reset.
    always_comb begin
        mfc0_data      = '0;
        cp0_read_addr  = '0;
        cp0_write_en   = 1'b0;
        cp0_write_addr = '0;
        cp0_write_data = '0;
        stall          = 1'b0;
        flush          = 1'b0;
        redirect_pc    = '0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    cp0_read_addr  = mfc0_addr;
                    mfc0_data      = cp0_rdata;
                    cp0_write_en   = mtc0_en && !exc_valid && !eret_valid;
                    cp0_write_addr = mtc0_addr;
                    cp0_write_data = mtc0_data;
                end
                X_RD_STATUS: begin
                    stall         = 1'b1;
                    cp0_read_addr = ADDR_STATUS;
                end
                X_RD_CAUSE: begin
                    stall         = 1'b1;
                    cp0_read_addr = ADDR_CAUSE;
                end
                X_WR_EPC: begin
                    stall          = 1'b1;
                    cp0_write_en   = 1'b1;
                    cp0_write_addr = ADDR_EPC;
                    cp0_write_data = pc_q;
                end
                X_WR_CAUSE: begin
                    stall          = 1'b1;
                    cp0_write_en   = 1'b1;
                    cp0_write_addr = ADDR_CAUSE;
                    cp0_write_data = {bd_q, cause_hi_q, code_q, cause_lo_q};
                end
                X_WR_STATUS: begin
                    stall          = 1'b1;
                    cp0_write_en   = 1'b1;
                    cp0_write_addr = ADDR_STATUS;
                    cp0_write_data = status_q | EXL_MASK;
                end
                R_RD_EPC: begin
                    stall         = 1'b1;
                    cp0_read_addr = ADDR_EPC;
                end
                R_RD_STATUS: begin
                    stall         = 1'b1;
                    cp0_read_addr = ADDR_STATUS;
                end
                R_WR_STATUS: begin
                    stall          = 1'b1;
                    cp0_write_en   = 1'b1;
                    cp0_write_addr = ADDR_STATUS;
                    cp0_write_data = status_q & ~EXL_MASK;
                end
                REDIRECT: begin
                    stall       = 1'b1;
                    flush       = 1'b1;
                    redirect_pc = eret_q ? epc_q : EXC_VECTOR;
                end
                default: begin
                    stall = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: CP0 register file model, directed vector table,
// random requests against a rule-level reference model, and reset/pass-through sequences.
module tb_cp0_exc_ctrl;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk, rst;
    logic        exc_valid, exc_bd, eret_valid, mtc0_en;
    logic [4:0]  exc_code, mtc0_addr, mfc0_addr, cp0_read_addr, cp0_write_addr;
    logic [31:0] exc_pc, mtc0_data, mfc0_data, cp0_rdata, cp0_write_data, redirect_pc;
    logic        cp0_write_en, stall, flush;

    logic [31:0] regs   [32];
    logic [31:0] shadow [32];
    logic        pl_en;
    logic [4:0]  pl_addr;
    logic [31:0] pl_data;

    int checks = 0;
    int errors = 0;

    cp0_exc_ctrl dut (
        .clk(clk), .rst(rst),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
        .eret_valid(eret_valid),
        .mtc0_en(mtc0_en), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data),
        .mfc0_addr(mfc0_addr), .mfc0_data(mfc0_data),
        .cp0_read_addr(cp0_read_addr), .cp0_rdata(cp0_rdata),
        .cp0_write_en(cp0_write_en), .cp0_write_addr(cp0_write_addr),
        .cp0_write_data(cp0_write_data),
        .stall(stall), .flush(flush), .redirect_pc(redirect_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // CP0 register file: combinational read, write at posedge, bench preload port.
    assign cp0_rdata = regs[cp0_read_addr];
    always @(posedge clk) begin
        if (pl_en) regs[pl_addr] <= pl_data;
        else if (cp0_write_en) regs[cp0_write_addr] <= cp0_write_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_bd = 1'b0; eret_valid = 1'b0;
        mtc0_en = 1'b0; mtc0_addr = '0; mtc0_data = '0; mfc0_addr = '0;
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        clear_inputs();
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        shadow[a] = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // One idle cycle of pipeline pass-through traffic.
    task automatic idle_cycle(input logic en, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [4:0] ra);
        @(negedge clk);
        clear_inputs();
        mtc0_en = en; mtc0_addr = wa; mtc0_data = wd; mfc0_addr = ra;
        #1;
        chk("idle_wen",   32'(cp0_write_en), 32'(en));
        chk("idle_waddr", 32'(cp0_write_addr), 32'(wa));
        chk("idle_wdata", cp0_write_data, wd);
        chk("idle_raddr", 32'(cp0_read_addr), 32'(ra));
        chk("idle_rdata", mfc0_data, shadow[ra]);
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_flush", 32'(flush), 32'd0);
        chk("idle_redir", redirect_pc, 32'd0);
        if (en) shadow[wa] = wd;
    endtask

    // Reference: the CP0 side effects of one request, from the architectural rules.
    task automatic model(input logic [1:0] kind, input logic [31:0] status, cause, epc,
                         input logic [4:0] code, input logic [31:0] pc, input logic bd,
                         output int nw, output logic [2:0][4:0] wa,
                         output logic [2:0][31:0] wd, output int fl, output logic [31:0] rd);
        wa = '0; wd = '0; nw = 0;
        if (kind == 2'd1) begin
            wa[0] = 5'd12; wd[0] = status & 32'hFFFF_FFFD; nw = 1;
            rd = epc;
        end else begin
            if (status[1] == 1'b0) begin
                wa[nw] = 5'd14; wd[nw] = pc; nw++;
            end
            wa[nw] = 5'd13;
            wd[nw] = (cause & 32'h7FFF_FF83) | (32'(bd) << 31) | (32'(code) << 2);
            nw++;
            wa[nw] = 5'd12; wd[nw] = status | 32'h2; nw++;
            rd = VEC;
        end
        // Two read cycles, the writes back to back, then the redirect cycle.
        fl = 3 + nw;
    endtask

    // Issue one request and follow it to the cycle after the flush.
    task automatic run_txn(input string tag, input logic [1:0] kind, input logic [4:0] code,
                           input logic [31:0] pc, input logic bd, input logic with_mtc0,
                           input logic junk, input int nw_exp, input logic [2:0][4:0] wa,
                           input logic [2:0][31:0] wd, input int fl_exp,
                           input logic [31:0] rd_exp);
        logic [4:0]  oa [4];
        logic [31:0] od [4];
        int          oc [4];
        int          nw_obs = 0;
        int          fcyc = 0;
        @(negedge clk);
        clear_inputs();
        exc_valid  = (kind != 2'd1);
        eret_valid = (kind != 2'd0);
        exc_code = code; exc_pc = pc; exc_bd = bd;
        mtc0_en = with_mtc0; mtc0_addr = 5'd14; mtc0_data = 32'hDEAD_BEEF;
        mfc0_addr = 5'($urandom);
        #1;
        chk({tag, "_accept_wen"},   32'(cp0_write_en), 32'd0);
        chk({tag, "_accept_stall"}, 32'(stall), 32'd0);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            clear_inputs();
            if (junk && c <= fl_exp) begin
                exc_valid = 1'($urandom); eret_valid = 1'($urandom); mtc0_en = 1'($urandom);
                mtc0_addr = 5'($urandom_range(12, 14)); mtc0_data = $urandom;
                exc_code = 5'($urandom); exc_pc = $urandom;
            end
            mfc0_addr = 5'($urandom);
            #1;
            if (fcyc == 0) begin
                chk($sformatf("%s_c%0d_stall", tag, c), 32'(stall), 32'd1);
                chk($sformatf("%s_c%0d_mfc0", tag, c), mfc0_data, 32'd0);
                if (cp0_write_en) begin
                    if (nw_obs < 4) begin
                        oa[nw_obs] = cp0_write_addr; od[nw_obs] = cp0_write_data; oc[nw_obs] = c;
                    end
                    nw_obs++;
                end
                if (flush) begin
                    fcyc = c;
                    chk({tag, "_redirect"}, redirect_pc, rd_exp);
                end else begin
                    chk($sformatf("%s_c%0d_redir0", tag, c), redirect_pc, 32'd0);
                end
            end else begin
                chk({tag, "_post_stall"}, 32'(stall), 32'd0);
                chk({tag, "_post_flush"}, 32'(flush), 32'd0);
                break;
            end
        end
        chk({tag, "_flush_cycle"}, 32'(fcyc), 32'(fl_exp));
        chk({tag, "_nwrites"}, 32'(nw_obs), 32'(nw_exp));
        for (int i = 0; i < nw_exp && i < nw_obs; i++) begin
            chk($sformatf("%s_w%0d_addr", tag, i), 32'(oa[i]), 32'(wa[i]));
            chk($sformatf("%s_w%0d_data", tag, i), od[i], wd[i]);
            chk($sformatf("%s_w%0d_cycle", tag, i), 32'(oc[i]), 32'(3 + i));
        end
        for (int i = 0; i < nw_exp; i++) shadow[wa[i]] = wd[i];
    endtask

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [4:0]  code;
        logic [31:0] pc;
        logic        bd;
        logic        mtc0;
        logic [3:0]  nw;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic [3:0]  fl;
        logic [31:0] redir;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int flush_seen;
        int wr_seen;
        logic [1:0]       kind;
        logic [31:0]      st, ca, ep, pc;
        logic [4:0]       code;
        logic             bd;
        int               nw, fl;
        logic [2:0][4:0]  wa;
        logic [2:0][31:0] wd;
        logic [31:0]      rd;

        // kind: 0 exception, 1 ERET, 2 exception and ERET together.
        vecs[0] = '{kind: 2'd0, status: 32'h0000_FF01, cause: 32'h0000_8000, epc: 32'h0,
                    code: 5'd4, pc: 32'hBFC0_0100, bd: 1'b1, mtc0: 1'b0, nw: 4'd3,
                    a0: 5'd14, a1: 5'd13, a2: 5'd12,
                    d0: 32'hBFC0_0100, d1: 32'h8000_8010, d2: 32'h0000_FF03,
                    fl: 4'd6, redir: 32'hBFC0_0380};
        vecs[1] = '{kind: 2'd0, status: 32'h0000_0003, cause: 32'h0000_8000, epc: 32'h5555_0000,
                    code: 5'd4, pc: 32'h8000_0044, bd: 1'b0, mtc0: 1'b0, nw: 4'd2,
                    a0: 5'd13, a1: 5'd12, a2: 5'd0,
                    d0: 32'h0000_8010, d1: 32'h0000_0003, d2: 32'h0,
                    fl: 4'd5, redir: 32'hBFC0_0380};
        vecs[2] = '{kind: 2'd1, status: 32'h0000_FF03, cause: 32'h0, epc: 32'h8000_1234,
                    code: 5'd0, pc: 32'h0, bd: 1'b0, mtc0: 1'b0, nw: 4'd1,
                    a0: 5'd12, a1: 5'd0, a2: 5'd0,
                    d0: 32'h0000_FF01, d1: 32'h0, d2: 32'h0,
                    fl: 4'd4, redir: 32'h8000_1234};
        vecs[3] = '{kind: 2'd0, status: 32'h0000_0000, cause: 32'hFFFF_FFFF, epc: 32'h0,
                    code: 5'd0, pc: 32'h0040_0010, bd: 1'b0, mtc0: 1'b1, nw: 4'd3,
                    a0: 5'd14, a1: 5'd13, a2: 5'd12,
                    d0: 32'h0040_0010, d1: 32'h7FFF_FF83, d2: 32'h0000_0002,
                    fl: 4'd6, redir: 32'hBFC0_0380};
        vecs[4] = '{kind: 2'd2, status: 32'h0000_0010, cause: 32'h0, epc: 32'h1234_5678,
                    code: 5'd12, pc: 32'h8000_0200, bd: 1'b0, mtc0: 1'b1, nw: 4'd3,
                    a0: 5'd14, a1: 5'd13, a2: 5'd12,
                    d0: 32'h8000_0200, d1: 32'h0000_0030, d2: 32'h0000_0012,
                    fl: 4'd6, redir: 32'hBFC0_0380};
        vecs[5] = '{kind: 2'd1, status: 32'hFFFF_FFFF, cause: 32'h0, epc: 32'hBFC0_0000,
                    code: 5'd0, pc: 32'h0, bd: 1'b0, mtc0: 1'b1, nw: 4'd1,
                    a0: 5'd12, a1: 5'd0, a2: 5'd0,
                    d0: 32'hFFFF_FFFD, d1: 32'h0, d2: 32'h0,
                    fl: 4'd4, redir: 32'hBFC0_0000};

        rst = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        clear_inputs();
        for (int i = 0; i < 32; i++) preload(5'(i), $urandom | 32'h1);

        // Reset: every output quiet even with live pipeline inputs.
        @(negedge clk);
        mtc0_en = 1'b1; mtc0_addr = 5'd12; mtc0_data = 32'hFFFF_FFFF; mfc0_addr = 5'd7;
        exc_valid = 1'b1;
        #1;
        chk("rst_wen",   32'(cp0_write_en), 32'd0);
        chk("rst_waddr", 32'(cp0_write_addr), 32'd0);
        chk("rst_wdata", cp0_write_data, 32'd0);
        chk("rst_raddr", 32'(cp0_read_addr), 32'd0);
        chk("rst_mfc0",  mfc0_data, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_redir", redirect_pc, 32'd0);
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;

        // Pass-through writes and reads.
        idle_cycle(1'b1, 5'd12, 32'h0000_FF01, 5'd13);
        idle_cycle(1'b0, 5'd0, 32'h0, 5'd12);
        idle_cycle(1'b1, 5'd3, 32'hCAFE_F00D, 5'd3);
        idle_cycle(1'b0, 5'd9, 32'h1, 5'd3);

        for (int i = 0; i < 6; i++) begin
            preload(5'd12, vecs[i].status);
            preload(5'd13, vecs[i].cause);
            preload(5'd14, vecs[i].epc);
            run_txn($sformatf("vec%0d", i), vecs[i].kind, vecs[i].code, vecs[i].pc, vecs[i].bd,
                    vecs[i].mtc0, 1'(i & 1), int'(vecs[i].nw),
                    {vecs[i].a2, vecs[i].a1, vecs[i].a0}, {vecs[i].d2, vecs[i].d1, vecs[i].d0},
                    int'(vecs[i].fl), vecs[i].redir);
        end

        // Reset in the middle of an exception sequence, during the Cause write.
        preload(5'd12, 32'h0);
        preload(5'd13, 32'h0);
        preload(5'd14, 32'h1111_1111);
        @(negedge clk);
        clear_inputs();
        exc_valid = 1'b1; exc_code = 5'd3; exc_pc = 32'hA000_0040;
        #1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            clear_inputs();
            #1;
            chk($sformatf("rstmid_c%0d_stall", c), 32'(stall), 32'd1);
        end
        chk("rstmid_epc_wen",   32'(cp0_write_en), 32'd1);
        chk("rstmid_epc_waddr", 32'(cp0_write_addr), 32'd14);
        chk("rstmid_epc_wdata", cp0_write_data, 32'hA000_0040);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmid_hold_wen",   32'(cp0_write_en), 32'd0);
        chk("rstmid_hold_stall", 32'(stall), 32'd0);
        chk("rstmid_hold_flush", 32'(flush), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid_idle_stall", 32'(stall), 32'd0);
        chk("rstmid_idle_flush", 32'(flush), 32'd0);
        chk("rstmid_idle_wen",   32'(cp0_write_en), 32'd0);
        shadow[14] = 32'hA000_0040;
        flush_seen = 0;
        wr_seen = 0;
        repeat (8) begin
            @(negedge clk);
            clear_inputs();
            #1;
            if (flush) flush_seen++;
            if (cp0_write_en) wr_seen++;
        end
        chk("rstmid_no_flush", 32'(flush_seen), 32'd0);
        chk("rstmid_no_write", 32'(wr_seen), 32'd0);
        idle_cycle(1'b0, 5'd0, 32'h0, 5'd12);
        idle_cycle(1'b0, 5'd0, 32'h0, 5'd13);
        idle_cycle(1'b0, 5'd0, 32'h0, 5'd14);

        // Random requests against the reference model.
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(1, 3))
                idle_cycle(1'($urandom), 5'($urandom), $urandom, 5'($urandom));
            kind = 2'($urandom_range(0, 2));
            st = $urandom; ca = $urandom; ep = $urandom; pc = $urandom;
            code = 5'($urandom); bd = 1'($urandom);
            preload(5'd12, st);
            preload(5'd13, ca);
            preload(5'd14, ep);
            model(kind, st, ca, ep, code, pc, bd, nw, wa, wd, fl, rd);
            run_txn($sformatf("rnd%0d", t), kind, code, pc, bd, 1'($urandom), 1'b1,
                    nw, wa, wd, fl, rd);
            idle_cycle(1'b0, 5'd0, 32'h0, 5'($urandom_range(12, 14)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
